control_unit: RTL and testbench
===============================

Name: control_unit

Overview:
- Multi-cycle control FSM that drives the CPU datapath.
- Consumes the 16-bit instruction held in IR and the ALU flags. Produces the full ctrl_sig_t control bundle each cycle.
- Sole driver of every ctrl_sig_t field. Implements fetch/decode/execute/memory/writeback sequencing, including a ready-handshake with data memory.

Parameters:
INSTR_WIDTH, 16, instruction width; opcode is instr[3:0].
MEM_TIMEOUT, 16, maximum cycles waiting on mem_ready before fault; 0 disables the timeout.

Ports:
clk  input  1  system clock, rising edge
resetn  input  1  asynchronous, active-low reset
instruct  input  INSTR_WIDTH  IR contents (ir_out)
flags  input  alu_flags_t  registered ALU flags {z,n,c,v}
mem_ready  input  1  data memory has completed the current read/write
sigs  output  ctrl_sig_t  control bundle; fields listed under Behaviour
halted  output  1  FSM is in HALT
fault  output  1  HALT was entered due to an illegal opcode or a memory timeout

Behaviour:
- ctrl_sig_t fields (defs_pkg):
  - PC_write, PC_sel[0] (0 adder, 1 {A,B}), ADDER_sel[1:0] (0 +2, 1 se8, 2 se12)
  - IR_load, RF_write, REG2_sel (0 ir[11:8], 1 ir[7:4]), REGW_sel[1:0] (0 ACC, 1 MDR, 2 imm8 ir[15:8]), AB_load
  - MAR_load, MDR_load, MDR_sel (0 mem, 1 reg B), ACC_load, FLAGS_load, ALU_op[2:0] (0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR), MEM_read, MEM_write
- All fields default to 0 in every state unless listed. Outputs are decoded from the state register plus instruct/flags; no output is registered separately.
- Reset (async, any state): state=FETCH1, sigs all zero, halted=0, fault=0, wait counter=0.
- States and transitions:
  - FETCH1: instruction ROM read cycle, no strobes -> FETCH2.
  - FETCH2: IR_load=1, PC_write=1, ADDER_sel=0 (PC+=2) -> DECODE.
  - DECODE: AB_load=1, REG2_sel=0. Opcode 0xF -> HALT (fault=0); opcode 0xE -> HALT (fault=1); LDI -> WB; NOP -> FETCH1; all others -> EXEC.
  - EXEC, per opcode:
    - ADD/SUB/AND/OR/XOR (0x1-0x5): ALU_op set, ACC_load=1, FLAGS_load=1 -> WB.
    - CMP (0xD): ALU_op=SUB, FLAGS_load=1 -> FETCH1.
    - BEQ (0x9): PC_write=flags.z, ADDER_sel=1 -> FETCH1.
    - BNE (0xA): PC_write=!flags.z, ADDER_sel=1 -> FETCH1.
    - JMP (0xB): PC_write=1, ADDER_sel=2 -> FETCH1.
    - JR (0xC): PC_write=1, PC_sel=1 -> FETCH1.
    - LD (0x7) / ST (0x8): MAR_load=1 (address {A,B}) -> MEM (LD) or STRD (ST).
  - Branch targets are relative to the already-incremented PC, i.e. PC_of_instr+2+offset.
  - STRD: AB_load=1, REG2_sel=1 (B=rf[ir[7:4]]) -> STDAT.
  - STDAT: MDR_load=1, MDR_sel=1 -> MEM.
  - MEM: MEM_read=1 (LD) or MEM_write=1 (ST), held while mem_ready=0.
    - On mem_ready=1: LD asserts MDR_load=1, MDR_sel=0 that cycle -> WB; ST -> FETCH1.
    - Wait counter increments each cycle mem_ready=0. When MEM_TIMEOUT!=0 and counter reaches MEM_TIMEOUT -> HALT with fault=1, strobes dropped.
    - Counter clears on leaving MEM.
  - WB: RF_write=1; REGW_sel=0 (ALU ops), 1 (LD), 2 (LDI 0x6) -> FETCH1.
  - HALT: all strobes 0, halted=1, fault held; exits only via reset.
- Cycle counts, FETCH1 to next FETCH1: NOP 3, LDI 4, ALU 5, CMP/branch/JMP/JR 4, LD 6+waits, ST 7+waits.
- Glitch-free intent: strobes must never be asserted in FETCH1 or HALT.

Test Plan:
- Reset: resetn low then high -> sigs==0, halted=0; IR_load=1 exactly in cycle 2, PC_write=1 ADDER_sel=0 same cycle.
- ADD, instruct=16'h3251 -> cycle3 AB_load; cycle4 ALU_op=0, ACC_load, FLAGS_load; cycle5 RF_write REGW_sel=0; next IR_load cycle7.
- BEQ, instruct=16'hFC09: flags.z=1 -> EXEC PC_write=1 ADDER_sel=1; repeat with z=0 -> PC_write=0, FETCH1 next either way.
- LD with mem_ready low 3 cycles -> MEM_read high 4 cycles; MDR_load on ready cycle; next cycle RF_write REGW_sel=1. ST -> STRD REG2_sel=1, STDAT MDR_sel=1, MEM_write until ready.
- mem_ready held low -> after 16 MEM cycles halted=1, fault=1, MEM_read=0 and stays. Opcode 0xF -> halted=1 fault=0; 0xE -> fault=1.
- resetn pulsed low mid-MEM (async, between edges) -> sigs zero immediately; restart at FETCH1.

Source files
------------

// File: rtl/control_unit.sv
// Multi-cycle control FSM for the 16-bit CPU datapath.
// Decodes IR and ALU flags into the ctrl_sig_t bundle each cycle.
package defs_pkg;

    typedef struct packed {
        logic z;
        logic n;
        logic c;
        logic v;
    } alu_flags_t;

    typedef struct packed {
        logic       PC_write;
        logic       PC_sel;
        logic [1:0] ADDER_sel;
        logic       IR_load;
        logic       RF_write;
        logic       REG2_sel;
        logic [1:0] REGW_sel;
        logic       AB_load;
        logic       MAR_load;
        logic       MDR_load;
        logic       MDR_sel;
        logic       ACC_load;
        logic       FLAGS_load;
        logic [2:0] ALU_op;
        logic       MEM_read;
        logic       MEM_write;
    } ctrl_sig_t;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_XOR = 3'd4;

endpackage

module control_unit
    import defs_pkg::*;
#(
    parameter int INSTR_WIDTH = 16,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [INSTR_WIDTH-1:0] instruct,
    input  alu_flags_t             flags,
    input  logic                   mem_ready,
    output ctrl_sig_t              sigs,
    output logic                   halted,
    output logic                   fault
);

    localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_AND = 4'h3;
    localparam logic [3:0] OP_OR  = 4'h4;
    localparam logic [3:0] OP_XOR = 4'h5;
    localparam logic [3:0] OP_LDI = 4'h6;
    localparam logic [3:0] OP_LD  = 4'h7;
    localparam logic [3:0] OP_ST  = 4'h8;
    localparam logic [3:0] OP_BEQ = 4'h9;
    localparam logic [3:0] OP_BNE = 4'hA;
    localparam logic [3:0] OP_JMP = 4'hB;
    localparam logic [3:0] OP_JR  = 4'hC;
    localparam logic [3:0] OP_CMP = 4'hD;
    localparam logic [3:0] OP_ILL = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [3:0] {
        S_FETCH1,
        S_FETCH2,
        S_DECODE,
        S_EXEC,
        S_STRD,
        S_STDAT,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    state_t        r_state;
    logic          r_fault;
    logic [CW-1:0] r_wait_cnt;

    logic [3:0]    w_op;
    logic          w_is_alu;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_timeout;
    logic          w_unused;

    assign w_op      = instruct[3:0];
    assign w_is_alu  = (w_op >= OP_ADD) && (w_op <= OP_XOR);
    assign w_cnt_nxt = r_wait_cnt + CW'(1);
    assign w_timeout = (MEM_TIMEOUT != 0) && (w_cnt_nxt == CW'(MEM_TIMEOUT));
    assign w_unused  = ^{instruct[INSTR_WIDTH-1:4], flags.n, flags.c, flags.v};

    // Sequencer: state, sticky fault flag and memory wait counter
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= S_FETCH1;
            r_fault    <= 1'b0;
            r_wait_cnt <= '0;
        end else begin
            case (r_state)
                S_FETCH1: r_state <= S_FETCH2;
                S_FETCH2: r_state <= S_DECODE;
                S_DECODE: begin
                    case (w_op)
                        OP_HLT:  r_state <= S_HALT;
                        OP_ILL: begin
                            r_state <= S_HALT;
                            r_fault <= 1'b1;
                        end
                        OP_LDI:  r_state <= S_WB;
                        OP_NOP:  r_state <= S_FETCH1;
                        default: r_state <= S_EXEC;
                    endcase
                end
                S_EXEC: begin
                    if (w_is_alu) begin
                        r_state <= S_WB;
                    end else if (w_op == OP_LD) begin
                        r_state <= S_MEM;
                    end else if (w_op == OP_ST) begin
                        r_state <= S_STRD;
                    end else begin
                        r_state <= S_FETCH1;
                    end
                end
                S_STRD:  r_state <= S_STDAT;
                S_STDAT: r_state <= S_MEM;
                S_MEM: begin
                    if (mem_ready) begin
                        r_wait_cnt <= '0;
                        r_state    <= (w_op == OP_LD) ? S_WB : S_FETCH1;
                    end else if (w_timeout) begin
                        r_wait_cnt <= '0;
                        r_state    <= S_HALT;
                        r_fault    <= 1'b1;
                    end else begin
                        r_wait_cnt <= w_cnt_nxt;
                    end
                end
                S_WB:    r_state <= S_FETCH1;
                S_HALT:  r_state <= S_HALT;
                default: r_state <= S_FETCH1;
            endcase
        end
    end

    // Control bundle decoded from the current state, opcode and flags
    always_comb begin
        sigs   = '0;
        halted = (r_state == S_HALT);
        fault  = r_fault;
        case (r_state)
            S_FETCH2: begin
                sigs.IR_load   = 1'b1;
                sigs.PC_write  = 1'b1;
                sigs.ADDER_sel = 2'd0;
            end
            S_DECODE: begin
                sigs.AB_load  = 1'b1;
                sigs.REG2_sel = 1'b0;
            end
            S_EXEC: begin
                case (w_op)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                        sigs.ACC_load   = 1'b1;
                        sigs.FLAGS_load = 1'b1;
                        case (w_op)
                            OP_SUB:  sigs.ALU_op = ALU_SUB;
                            OP_AND:  sigs.ALU_op = ALU_AND;
                            OP_OR:   sigs.ALU_op = ALU_OR;
                            OP_XOR:  sigs.ALU_op = ALU_XOR;
                            default: sigs.ALU_op = ALU_ADD;
                        endcase
                    end
                    OP_CMP: begin
                        sigs.ALU_op     = ALU_SUB;
                        sigs.FLAGS_load = 1'b1;
                    end
                    OP_BEQ: begin
                        sigs.PC_write  = flags.z;
                        sigs.ADDER_sel = 2'd1;
                    end
                    OP_BNE: begin
                        sigs.PC_write  = !flags.z;
                        sigs.ADDER_sel = 2'd1;
                    end
                    OP_JMP: begin
                        sigs.PC_write  = 1'b1;
                        sigs.ADDER_sel = 2'd2;
                    end
                    OP_JR: begin
                        sigs.PC_write = 1'b1;
                        sigs.PC_sel   = 1'b1;
                    end
                    OP_LD, OP_ST: begin
                        sigs.MAR_load = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_STRD: begin
                sigs.AB_load  = 1'b1;
                sigs.REG2_sel = 1'b1;
            end
            S_STDAT: begin
                sigs.MDR_load = 1'b1;
                sigs.MDR_sel  = 1'b1;
            end
            S_MEM: begin
                if (w_op == OP_LD) begin
                    sigs.MEM_read = 1'b1;
                    sigs.MDR_load = mem_ready;
                    sigs.MDR_sel  = 1'b0;
                end else begin
                    sigs.MEM_write = 1'b1;
                end
            end
            S_WB: begin
                sigs.RF_write = 1'b1;
                if (w_op == OP_LD) begin
                    sigs.REGW_sel = 2'd1;
                end else if (w_op == OP_LDI) begin
                    sigs.REGW_sel = 2'd2;
                end else begin
                    sigs.REGW_sel = 2'd0;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Directed-vector bench for control_unit.
// Table of per-cycle expectations plus multi-cycle memory/reset sequences.
module tb_control_unit;
    import defs_pkg::*;

    logic       clk;
    logic       resetn;
    logic [15:0] instruct;
    alu_flags_t flags;
    logic       mem_ready;
    ctrl_sig_t  sigs;
    logic       halted;
    logic       fault;

    int errors = 0;
    int checks = 0;

    control_unit #(
        .INSTR_WIDTH(16),
        .MEM_TIMEOUT(16)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .instruct (instruct),
        .flags    (flags),
        .mem_ready(mem_ready),
        .sigs     (sigs),
        .halted   (halted),
        .fault    (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      nm;
        logic [15:0] ins;
        logic       z;
        int         cyc;
        ctrl_sig_t  e;
        logic       h;
        logic       f;
    } vec_t;

    vec_t tv[$];
    vec_t v;

    function automatic vec_t mkv(string nm, logic [15:0] ins, logic z,
                                 int cyc, logic h, logic f);
        vec_t r;
        r.nm  = nm;
        r.ins = ins;
        r.z   = z;
        r.cyc = cyc;
        r.e   = '0;
        r.h   = h;
        r.f   = f;
        return r;
    endfunction

    task automatic chk(string nm, ctrl_sig_t es, logic eh, logic ef);
        checks++;
        if (sigs !== es || halted !== eh || fault !== ef) begin
            errors++;
            $display("FAIL %s: got sigs=%h halted=%b fault=%b, want sigs=%h halted=%b fault=%b",
                     nm, sigs, halted, fault, es, eh, ef);
        end
    endtask

    // Leaves the DUT in FETCH1 at cycle 1, sampled 1ns after a negedge.
    task automatic do_reset();
        resetn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        #1;
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    ctrl_sig_t e;

    initial begin
        resetn    = 1'b0;
        instruct  = 16'h0000;
        flags     = '0;
        mem_ready = 1'b1;

        v = mkv("reset_c1", 16'h3251, 0, 1, 0, 0); tv.push_back(v);
        v = mkv("fetch2_c2", 16'h3251, 0, 2, 0, 0);
        v.e.IR_load = 1; v.e.PC_write = 1; tv.push_back(v);
        v = mkv("add_dec", 16'h3251, 0, 3, 0, 0);
        v.e.AB_load = 1; tv.push_back(v);
        v = mkv("add_exec", 16'h3251, 0, 4, 0, 0);
        v.e.ACC_load = 1; v.e.FLAGS_load = 1; tv.push_back(v);
        v = mkv("add_wb", 16'h3251, 0, 5, 0, 0);
        v.e.RF_write = 1; tv.push_back(v);
        v = mkv("add_f1", 16'h3251, 0, 6, 0, 0); tv.push_back(v);
        v = mkv("add_next_ir", 16'h3251, 0, 7, 0, 0);
        v.e.IR_load = 1; v.e.PC_write = 1; tv.push_back(v);
        v = mkv("sub_exec", 16'h0002, 0, 4, 0, 0);
        v.e.ALU_op = 3'd1; v.e.ACC_load = 1; v.e.FLAGS_load = 1; tv.push_back(v);
        v = mkv("or_exec", 16'h0004, 0, 4, 0, 0);
        v.e.ALU_op = 3'd3; v.e.ACC_load = 1; v.e.FLAGS_load = 1; tv.push_back(v);
        v = mkv("xor_exec", 16'h0005, 0, 4, 0, 0);
        v.e.ALU_op = 3'd4; v.e.ACC_load = 1; v.e.FLAGS_load = 1; tv.push_back(v);
        v = mkv("beq_z1", 16'hFC09, 1, 4, 0, 0);
        v.e.PC_write = 1; v.e.ADDER_sel = 2'd1; tv.push_back(v);
        v = mkv("beq_z1_f1", 16'hFC09, 1, 5, 0, 0); tv.push_back(v);
        v = mkv("beq_z0", 16'hFC09, 0, 4, 0, 0);
        v.e.ADDER_sel = 2'd1; tv.push_back(v);
        v = mkv("beq_z0_f1", 16'hFC09, 0, 5, 0, 0); tv.push_back(v);
        v = mkv("beq_z0_ir", 16'hFC09, 0, 6, 0, 0);
        v.e.IR_load = 1; v.e.PC_write = 1; tv.push_back(v);
        v = mkv("bne_z0", 16'h000A, 0, 4, 0, 0);
        v.e.PC_write = 1; v.e.ADDER_sel = 2'd1; tv.push_back(v);
        v = mkv("bne_z1", 16'h000A, 1, 4, 0, 0);
        v.e.ADDER_sel = 2'd1; tv.push_back(v);
        v = mkv("jmp_exec", 16'h000B, 0, 4, 0, 0);
        v.e.PC_write = 1; v.e.ADDER_sel = 2'd2; tv.push_back(v);
        v = mkv("jr_exec", 16'h000C, 0, 4, 0, 0);
        v.e.PC_write = 1; v.e.PC_sel = 1; tv.push_back(v);
        v = mkv("cmp_exec", 16'h000D, 0, 4, 0, 0);
        v.e.ALU_op = 3'd1; v.e.FLAGS_load = 1; tv.push_back(v);
        v = mkv("cmp_ir", 16'h000D, 0, 6, 0, 0);
        v.e.IR_load = 1; v.e.PC_write = 1; tv.push_back(v);
        v = mkv("nop_f1", 16'h0000, 0, 4, 0, 0); tv.push_back(v);
        v = mkv("nop_ir", 16'h0000, 0, 5, 0, 0);
        v.e.IR_load = 1; v.e.PC_write = 1; tv.push_back(v);
        v = mkv("ldi_wb", 16'h1206, 0, 4, 0, 0);
        v.e.RF_write = 1; v.e.REGW_sel = 2'd2; tv.push_back(v);
        v = mkv("ldi_ir", 16'h1206, 0, 6, 0, 0);
        v.e.IR_load = 1; v.e.PC_write = 1; tv.push_back(v);
        v = mkv("halt_op", 16'h000F, 0, 4, 1, 0); tv.push_back(v);
        v = mkv("halt_stay", 16'h000F, 0, 9, 1, 0); tv.push_back(v);
        v = mkv("illegal_op", 16'h000E, 0, 4, 1, 1); tv.push_back(v);
        v = mkv("ld_exec", 16'h0017, 0, 4, 0, 0);
        v.e.MAR_load = 1; tv.push_back(v);
        v = mkv("ld_mem_rdy", 16'h0017, 0, 5, 0, 0);
        v.e.MEM_read = 1; v.e.MDR_load = 1; tv.push_back(v);
        v = mkv("ld_wb", 16'h0017, 0, 6, 0, 0);
        v.e.RF_write = 1; v.e.REGW_sel = 2'd1; tv.push_back(v);
        v = mkv("ld_ir", 16'h0017, 0, 8, 0, 0);
        v.e.IR_load = 1; v.e.PC_write = 1; tv.push_back(v);
        v = mkv("st_exec", 16'h0028, 0, 4, 0, 0);
        v.e.MAR_load = 1; tv.push_back(v);
        v = mkv("st_strd", 16'h0028, 0, 5, 0, 0);
        v.e.AB_load = 1; v.e.REG2_sel = 1; tv.push_back(v);
        v = mkv("st_stdat", 16'h0028, 0, 6, 0, 0);
        v.e.MDR_load = 1; v.e.MDR_sel = 1; tv.push_back(v);
        v = mkv("st_mem", 16'h0028, 0, 7, 0, 0);
        v.e.MEM_write = 1; tv.push_back(v);
        v = mkv("st_f1", 16'h0028, 0, 8, 0, 0); tv.push_back(v);
        v = mkv("st_ir", 16'h0028, 0, 9, 0, 0);
        v.e.IR_load = 1; v.e.PC_write = 1; tv.push_back(v);

        foreach (tv[i]) begin
            instruct  = tv[i].ins;
            flags     = '0;
            flags.z   = tv[i].z;
            mem_ready = 1'b1;
            do_reset();
            repeat (tv[i].cyc - 1) step();
            chk(tv[i].nm, tv[i].e, tv[i].h, tv[i].f);
        end

        // LD with three wait cycles
        instruct  = 16'h0017;
        flags     = '0;
        mem_ready = 1'b0;
        do_reset();
        repeat (4) step();
        for (int c = 5; c <= 7; c++) begin
            e = '0; e.MEM_read = 1;
            chk($sformatf("ld_wait_c%0d", c), e, 0, 0);
            step();
        end
        mem_ready = 1'b1;
        #1;
        e = '0; e.MEM_read = 1; e.MDR_load = 1;
        chk("ld_wait_ready", e, 0, 0);
        step();
        e = '0; e.RF_write = 1; e.REGW_sel = 2'd1;
        chk("ld_wait_wb", e, 0, 0);
        step();
        chk("ld_wait_f1", '0, 0, 0);

        // ST with two wait cycles
        instruct  = 16'h0028;
        mem_ready = 1'b0;
        do_reset();
        repeat (6) step();
        for (int c = 7; c <= 8; c++) begin
            e = '0; e.MEM_write = 1;
            chk($sformatf("st_wait_c%0d", c), e, 0, 0);
            step();
        end
        mem_ready = 1'b1;
        #1;
        e = '0; e.MEM_write = 1;
        chk("st_wait_ready", e, 0, 0);
        step();
        chk("st_wait_f1", '0, 0, 0);

        // Memory timeout: 16 MEM cycles then faulted HALT
        instruct  = 16'h0017;
        mem_ready = 1'b0;
        do_reset();
        repeat (19) step();
        e = '0; e.MEM_read = 1;
        chk("timeout_last_mem", e, 0, 0);
        step();
        chk("timeout_halt", '0, 1, 1);
        repeat (5) step();
        mem_ready = 1'b1;
        #1;
        chk("timeout_stays", '0, 1, 1);

        // Wait counter clears between accesses: two LDs with 10 waits each
        instruct  = 16'h0017;
        mem_ready = 1'b0;
        do_reset();
        for (int c = 2; c <= 31; c++) begin
            @(negedge clk);
            mem_ready = (c == 15 || c == 31);
            #1;
        end
        e = '0; e.MEM_read = 1; e.MDR_load = 1;
        chk("cnt_clear_2nd_ld", e, 0, 0);

        // Async reset mid-MEM
        instruct  = 16'h0017;
        mem_ready = 1'b0;
        do_reset();
        repeat (6) step();
        @(posedge clk);
        #3;
        resetn = 1'b0;
        #1;
        chk("async_rst_now", '0, 0, 0);
        @(negedge clk);
        resetn    = 1'b1;
        mem_ready = 1'b1;
        #1;
        chk("async_rst_f1", '0, 0, 0);
        step();
        e = '0; e.IR_load = 1; e.PC_write = 1;
        chk("async_rst_f2", e, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
